// File: rtl/op_dispatch_pkg.sv
// op_dispatch_pkg: shared op codes, FSM state encoding and default width
// for the op_dispatcher block and its timeout helper.
package op_dispatch_pkg;

  localparam int DATA_W_DEF = 64;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

endpackage

// File: rtl/dispatch_timer.sv
// dispatch_timer: watchdog counter for the dispatcher wait states.
// Only instantiated when DISPATCH_TIMEOUT_EN is defined.
// expired flags the cycle whose closing edge brings the count to LIMIT.
module dispatch_timer #(
  parameter int LIMIT = 255,
  parameter int CNT_W = ($clog2(LIMIT + 1) > 8) ? $clog2(LIMIT + 1) : 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [CNT_W-1:0] cnt;

  // Restart on entry to a wait state, count every cycle spent waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = run && (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/op_dispatcher.sv
// op_dispatcher: accepts one operation request, pulses the selected unit's
// start, tracks that unit's working flag and returns its result.
// Optional macro DISPATCH_TIMEOUT_EN adds a watchdog that aborts a stuck
// unit with rsp_err=1 after TIMEOUT_CYCLES cycles in a wait state.
module op_dispatcher
  import op_dispatch_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [DATA_W-1:0]     req_a,
  input  logic [DATA_W-1:0]     req_b,
  output logic [3:0]            unit_start,
  output logic [DATA_W-1:0]     unit_a,
  output logic [DATA_W-1:0]     unit_b,
  input  logic [3:0]            unit_working,
  input  logic [4*DATA_W-1:0]   unit_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_result,
  output logic [1:0]            rsp_op,
  output logic                  rsp_err
);

  state_t                  state;
  logic [1:0]              op_q;
  logic [3:0][DATA_W-1:0]  slices;
  logic                    working_sel;
  logic                    timeout;

  assign slices      = unit_result;
  assign working_sel = unit_working[op_q];
  assign rsp_op      = op_q;

`ifdef DISPATCH_TIMEOUT_EN
  logic expired;
  logic in_wait;
  logic enter_wait;
  logic progress;
  logic err_q;

  assign in_wait    = (state == WAIT_BUSY) || (state == WAIT_DONE);
  assign enter_wait = (state == START) || ((state == WAIT_BUSY) && working_sel);
  assign progress   = ((state == WAIT_BUSY) && working_sel) ||
                      ((state == WAIT_DONE) && !working_sel);

  dispatch_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (enter_wait),
    .run     (in_wait),
    .expired (expired)
  );

  // A unit that makes progress on the expiring cycle still wins.
  assign timeout = expired && !progress;

  // Error flag is set by an abort and cleared by a normal completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (timeout) begin
      err_q <= 1'b1;
    end else if ((state == WAIT_DONE) && !working_sel) begin
      err_q <= 1'b0;
    end
  end

  assign rsp_err = err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // Main sequencer with registered handshake and unit-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      unit_start <= '0;
      unit_a     <= '0;
      unit_b     <= '0;
      op_q       <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
    end else begin
      unit_start <= '0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_q       <= req_op;
            unit_a     <= req_a;
            unit_b     <= req_b;
            unit_start <= 4'b0001 << req_op;
            req_ready  <= 1'b0;
            state      <= START;
          end
        end
        START: begin
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (working_sel) begin
            state <= WAIT_DONE;
          end else if (timeout) begin
            rsp_result <= '0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end
        end
        WAIT_DONE: begin
          if (!working_sel) begin
            rsp_result <= slices[op_q];
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end else if (timeout) begin
            rsp_result <= '0;
            rsp_valid  <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
